haar_dwt_sched: RTL
===================

// Module: haar_dwt_sched
// PURPOSE
//  Multi-level Haar DWT sequencer. Loads one frame of SIGNAL_LENGTH signed samples into a local buffer, then
//  runs LEVELS in-place passes through one shared pairwise Haar butterfly, one pair per cycle. Emits every
//  coefficient on a valid/ready stream. Sits between the sample front-end and the coefficient consumer/packer.
// PARAMETERS
//  DATA_WIDTH     8  two's-complement sample/coefficient width
//  SIGNAL_LENGTH  8  frame length N; power of 2, >=2
//  LEVELS         3  decomposition depth; 1..log2(N)
// PORTS
//  clk            in   1               single clock, rising edge
//  rst_n          in   1               asynchronous, active-low reset
//  in_valid       in   1               sample offered
//  in_ready       out  1               sample accepted when in_valid&&in_ready
//  in_data        in   DATA_WIDTH      signed sample
//  out_valid      out  1               coefficient offered
//  out_ready      in   1               consumer accepts
//  out_data       out  DATA_WIDTH      signed coefficient
//  out_is_detail  out  1               1=detail, 0=final approximation
//  out_level      out  LVL_W           level of coefficient, 1..LEVELS
//  out_last       out  1               last coefficient of frame
//  busy           out  1               state != IDLE
//  frame_done     out  1               one-cycle pulse, cycle after out_last handshake
// BEHAVIOUR
//  Reset: state=IDLE, out_valid/out_data/out_is_detail/out_level/out_last/frame_done=0, counters=0,
//   in_ready=1. Buffer not reset. Reset mid-frame discards the frame; no partial output after release.
//  FSM: IDLE -(in handshake)-> LOAD -(N-th sample)-> COMPUTE -(last pair of level LEVELS)-> DRAIN
//   -(out_last handshake)-> IDLE. IDLE's accepted sample is buf[0]; samples stored in arrival order.
//  in_ready=1 only in IDLE/LOAD; in_valid ignored otherwise.
//  COMPUTE level l (1..LEVELS): M=N>>l pairs, j=0..M-1 ascending, one per cycle:
//   a=(buf[2j]+buf[2j+1])>>>1, d=(buf[2j]-buf[2j+1])>>>1, computed at DATA_WIDTH+1 bits, arithmetic
//   shift (floor), truncated to DATA_WIDTH (always fits). a written to buf[j] (in-place safe: ascending j).
//   d loaded into output register with out_is_detail=1, out_level=l.
//  DRAIN: emits buf[0..(N>>LEVELS)-1] with out_is_detail=0, out_level=LEVELS; out_last on final one.
//  Output order: all level-1 details, level-2 details, ..., final approximations. Exactly N outputs/frame.
//  Output register advances only when slot free (!out_valid || out_ready); otherwise FSM, counters and
//   buffer stall; out_* held stable while out_valid && !out_ready.
//  Throughput with out_ready=1: N load cycles + N output cycles; back-to-back frames, 1 idle cycle between.
//  frame_done and IDLE entry on cycle after out_last handshake; in_ready=1 that same cycle.
// STRUCTURE
//  Package haar_dwt_pkg: state enum {IDLE,LOAD,COMPUTE,DRAIN}; LVL_W=$clog2(LEVELS+1); IDX_W=$clog2(N);
//   function haar_pair(x0,x1) returning {a,d} with the width rule above.
//  Sub-module haar_pair_unit: combinational butterfly wrapping haar_pair; single instance, shared by all levels.
//  Elaboration checks: N power of 2, 1<=LEVELS<=log2(N).
// TESTING
//  1 N=8,L=3, in 10,20,...,80, out_ready=1 -> out -5,-5,-5,-5(l1) -10,-10(l2) -20(l3) 45(approx,last).
//  2 Extremes: in -128,127 then 0s -> first d=-128, a=-1; zero pairs give 0; no wrap.
//  3 Floor: pair (0,3) -> a=1, d=-2; pair (3,0) -> a=1, d=1.
//  4 Backpressure: out_ready=0 for 5 cycles mid-level-1 -> out_data held, sequence identical to test 1.
//  5 Reset mid-COMPUTE after 3 outputs -> out_valid=0, busy=0, in_ready=1; next frame matches test 1.
//  6 LEVELS=1, same input -> 4x -5 (l1 detail) then 15,35,55,75 (approx), out_last on 75, frame_done next cycle.

Source files
------------

// File: rtl/haar_dwt_pkg.sv
// haar_dwt_pkg: shared state encoding and Haar butterfly arithmetic
package haar_dwt_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_e;

    typedef struct packed {
        logic signed [31:0] a;
        logic signed [31:0] d;
    } pair_t;

    // Floor-halved sum and difference; callers sign-extend into 32 bits so any width below 32 is exact
    function automatic pair_t haar_pair(input logic signed [31:0] x0, input logic signed [31:0] x1);
        pair_t p;
        p.a = (x0 + x1) >>> 1;
        p.d = (x0 - x1) >>> 1;
        return p;
    endfunction

endpackage

// File: rtl/haar_dwt_sched_pair_unit.sv
// haar_pair_unit: combinational Haar butterfly shared by every decomposition level
module haar_pair_unit
    import haar_dwt_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic signed [DATA_WIDTH-1:0] x0_i,
    input  logic signed [DATA_WIDTH-1:0] x1_i,
    output logic signed [DATA_WIDTH-1:0] a_o,
    output logic signed [DATA_WIDTH-1:0] d_o
);

    pair_t r;
    logic [31-DATA_WIDTH:0] unused_a_hi;
    logic [31-DATA_WIDTH:0] unused_d_hi;

    assign r = haar_pair(32'(x0_i), 32'(x1_i));
    assign {unused_a_hi, a_o} = r.a;
    assign {unused_d_hi, d_o} = r.d;

endmodule

// File: rtl/haar_dwt_sched.sv
// haar_dwt_sched: frame loader, in-place multi-level Haar DWT and coefficient streamer
module haar_dwt_sched
    import haar_dwt_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int SIGNAL_LENGTH = 8,
    parameter int LEVELS        = 3,
    localparam int LVL_W        = $clog2(LEVELS + 1),
    localparam int IDX_W        = $clog2(SIGNAL_LENGTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic signed [DATA_WIDTH-1:0] in_data_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic signed [DATA_WIDTH-1:0] out_data_o,
    output logic                         out_is_detail_o,
    output logic [LVL_W-1:0]             out_level_o,
    output logic                         out_last_o,
    output logic                         busy_o,
    output logic                         frame_done_o
);

    localparam int N  = SIGNAL_LENGTH;
    localparam int NA = N >> LEVELS;

    if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_len
        $error("SIGNAL_LENGTH must be a power of 2 and at least 2");
    end
    if (LEVELS < 1 || LEVELS > $clog2(N)) begin : g_bad_lvl
        $error("LEVELS must lie in 1..log2(SIGNAL_LENGTH)");
    end

    state_e                      state_q, state_d;
    logic [IDX_W-1:0]            cnt_q, cnt_d;
    logic [LVL_W-1:0]            lvl_q, lvl_d;
    logic signed [DATA_WIDTH-1:0] mem_q [N];
    logic                        out_valid_q, out_valid_d;
    logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                        out_det_q, out_det_d;
    logic [LVL_W-1:0]            out_lvl_q, out_lvl_d;
    logic                        out_last_q, out_last_d;
    logic                        done_q, done_d;
    logic                        wr_en;
    logic [IDX_W-1:0]            wr_idx;
    logic signed [DATA_WIDTH-1:0] wr_data;
    logic signed [DATA_WIDTH-1:0] pa, pd;
    logic                        adv, in_hs, last_pair, last_lvl, last_appr, last_hs;

    // The output slot gates all progress so that stalls freeze FSM, counters and buffer together
    assign adv       = !out_valid_q || out_ready_i;
    assign in_hs     = in_valid_i && in_ready_o;
    assign last_pair = cnt_q == IDX_W'((N >> lvl_q) - 1);
    assign last_lvl  = lvl_q == LVL_W'(LEVELS);
    assign last_appr = cnt_q == IDX_W'(NA - 1);
    assign last_hs   = out_valid_q && out_last_q && out_ready_i;

    haar_pair_unit #(.DATA_WIDTH(DATA_WIDTH)) u_pair (
        .x0_i (mem_q[cnt_q << 1]),
        .x1_i (mem_q[(cnt_q << 1) | 1'b1]),
        .a_o  (pa),
        .d_o  (pd)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: load N samples, run all levels, drain approximations, return after last handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = in_hs ? LOAD : IDLE;
            LOAD:    state_d = (in_hs && cnt_q == IDX_W'(N - 1)) ? COMPUTE : LOAD;
            COMPUTE: state_d = (adv && last_pair && last_lvl) ? DRAIN : COMPUTE;
            DRAIN:   state_d = last_hs ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        in_ready_o = state_q == IDLE || state_q == LOAD;
        busy_o     = state_q != IDLE;
    end

    // Datapath next values: buffer writes, counters and the coefficient register
    always_comb begin
        cnt_d       = cnt_q;
        lvl_d       = lvl_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_det_d   = out_det_q;
        out_lvl_d   = out_lvl_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        wr_en       = 1'b0;
        wr_idx      = cnt_q;
        wr_data     = in_data_i;
        case (state_q)
            IDLE: begin
                wr_en  = in_hs;
                wr_idx = '0;
                cnt_d  = in_hs ? IDX_W'(1) : '0;
            end
            LOAD: begin
                wr_en = in_hs;
                cnt_d = in_hs ? cnt_q + 1'b1 : cnt_q;
                lvl_d = LVL_W'(1);
            end
            COMPUTE: if (adv) begin
                wr_en       = 1'b1;
                wr_data     = pa;
                out_valid_d = 1'b1;
                out_data_d  = pd;
                out_det_d   = 1'b1;
                out_lvl_d   = lvl_q;
                out_last_d  = 1'b0;
                cnt_d       = last_pair ? '0 : cnt_q + 1'b1;
                lvl_d       = (last_pair && !last_lvl) ? lvl_q + 1'b1 : lvl_q;
            end
            DRAIN: if (last_hs) begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                done_d      = 1'b1;
                cnt_d       = '0;
            end else if (adv) begin
                out_valid_d = 1'b1;
                out_data_d  = mem_q[cnt_q];
                out_det_d   = 1'b0;
                out_lvl_d   = LVL_W'(LEVELS);
                out_last_d  = last_appr;
                cnt_d       = cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    // Counters and coefficient register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            lvl_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_det_q   <= 1'b0;
            out_lvl_q   <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            lvl_q       <= lvl_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_det_q   <= out_det_d;
            out_lvl_q   <= out_lvl_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    // Sample/approximation buffer; contents are don't-care until a frame is loaded
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= wr_data;
    end

    assign out_valid_o     = out_valid_q;
    assign out_data_o      = out_data_q;
    assign out_is_detail_o = out_det_q;
    assign out_level_o     = out_lvl_q;
    assign out_last_o      = out_last_q;
    assign frame_done_o    = done_q;

endmodule
